// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer: owns the PC and steps each instruction through fetch, execute,
// optional LSU access and commit. Optional performance counters are enabled by MC_CTRL_PERF_EN.
module mc_ctrl #(
    parameter int unsigned         XLEN         = 32,
    parameter logic [XLEN-1:0]     RESET_VECTOR = 32'h8000_0000,
    parameter int unsigned         CNT_W        = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             ifu_req_valid_o,
    output logic [XLEN-1:0]  ifu_req_addr_o,
    input  logic             ifu_req_ready_i,
    input  logic             ifu_rsp_valid_i,
    input  logic [31:0]      ifu_rsp_inst_i,
    output logic [31:0]      inst_o,
    output logic [XLEN-1:0]  pc_o,
    input  logic             jal_i,
    input  logic             jalr_i,
    input  logic             br_taken_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic             mem_i,
    input  logic             ebreak_i,
    output logic             lsu_req_valid_o,
    input  logic             lsu_req_ready_i,
    input  logic             lsu_rsp_valid_i,
    output logic             rd_wen_o,
    output logic             commit_o,
    output logic [XLEN-1:0]  commit_pc_o,
    output logic [31:0]      commit_inst_o,
`ifdef MC_CTRL_PERF_EN
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instret_cnt_o,
`endif
    output logic             halt_o
);

    typedef enum logic [2:0] {
        StFetchReq,
        StFetchWait,
        StExec,
        StMemReq,
        StMemWait,
        StHalt
    } state_e;

    state_e          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc_r;
    logic [31:0]     inst;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] off;
    logic [XLEN-1:0] npc;

    if (XLEN < 2) begin : g_xlen_check
        $error("mc_ctrl: XLEN must be at least 2");
    end
    if (CNT_W == 0) begin : g_cnt_w_check
        $error("mc_ctrl: CNT_W must be nonzero");
    end

    always_comb begin
        base = jalr_i ? rs1_i : pc;
        off  = (jal_i | jalr_i | br_taken_i) ? imm_i : XLEN'(4);
        npc  = base + off;
        if (jalr_i) begin
            npc[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= StFetchReq;
            pc    <= RESET_VECTOR;
            inst  <= '0;
            npc_r <= '0;
        end else begin
            case (state)
                StFetchReq: begin
                    if (ifu_req_ready_i) state <= StFetchWait;
                end
                StFetchWait: begin
                    if (ifu_rsp_valid_i) begin
                        inst  <= ifu_rsp_inst_i;
                        state <= StExec;
                    end
                end
                StExec: begin
                    npc_r <= npc;
                    if (ebreak_i) begin
                        state <= StHalt;
                    end else if (mem_i) begin
                        state <= StMemReq;
                    end else begin
                        pc    <= npc;
                        state <= StFetchReq;
                    end
                end
                StMemReq: begin
                    if (lsu_req_ready_i) state <= StMemWait;
                end
                StMemWait: begin
                    if (lsu_rsp_valid_i) begin
                        pc    <= npc_r;
                        state <= StFetchReq;
                    end
                end
                StHalt: begin
                    state <= StHalt;
                end
                default: begin
                    state <= StFetchReq;
                end
            endcase
        end
    end

    // Request valids come from state only; reset masks the fetch request.
    always_comb begin
        ifu_req_valid_o = (state == StFetchReq) && !rst_i;
        lsu_req_valid_o = (state == StMemReq);
        halt_o          = (state == StHalt);
        commit_o        = ((state == StExec) && (ebreak_i || !mem_i)) ||
                          ((state == StMemWait) && lsu_rsp_valid_i);
        rd_wen_o        = ((state == StExec) && !ebreak_i && !mem_i) ||
                          ((state == StMemWait) && lsu_rsp_valid_i);
        commit_pc_o     = commit_o ? pc : '0;
        commit_inst_o   = commit_o ? inst : '0;
    end

    assign ifu_req_addr_o = pc;
    assign pc_o           = pc;
    assign inst_o         = inst;

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != StHalt) cycle_cnt <= cycle_cnt + 1'b1;
            if (commit_o) instret_cnt <= instret_cnt + 1'b1;
        end
    end

    assign cycle_cnt_o   = cycle_cnt;
    assign instret_cnt_o = instret_cnt;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed vector table, EBREAK/reset sequences and a randomized
// instruction stream checked against a PC-level reference model.
module tb_mc_ctrl;

    localparam int unsigned   XLEN = 32;
    localparam logic [31:0]   RV   = 32'h8000_0000;
    localparam int unsigned   CW   = 4;

    typedef enum int {KAlu, KJal, KJalr, KBrT, KBrN, KLoad, KEbreak} kind_e;

    typedef struct {
        logic [31:0] pc;
        kind_e       k;
        logic [31:0] imm;
        logic [31:0] rs1;
        int          rqw;
        int          rsw;
        int          lqw;
        int          lsw;
        bit          spur;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        ifu_req_ready_i = 1'b0;
    logic        ifu_rsp_valid_i = 1'b0;
    logic [31:0] ifu_rsp_inst_i = '0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        jal_i = 1'b0;
    logic        jalr_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic [31:0] imm_i = '0;
    logic [31:0] rs1_i = '0;
    logic        mem_i = 1'b0;
    logic        ebreak_i = 1'b0;
    logic        lsu_req_valid;
    logic        lsu_req_ready_i = 1'b0;
    logic        lsu_rsp_valid_i = 1'b0;
    logic        rd_wen;
    logic        commit;
    logic [31:0] commit_pc;
    logic [31:0] commit_inst;
    logic        halt;
`ifdef MC_CTRL_PERF_EN
    logic [CW-1:0] cycle_cnt;
    logic [CW-1:0] instret_cnt;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [31:0] pc_m;
    logic [31:0] last_inst_m;
    int          cyc_m;
    int          ret_m;
    bit          halted_m;
    vec_t        tbl[11];

    mc_ctrl #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .CNT_W        (CW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ifu_req_valid_o (ifu_req_valid),
        .ifu_req_addr_o  (ifu_req_addr),
        .ifu_req_ready_i (ifu_req_ready_i),
        .ifu_rsp_valid_i (ifu_rsp_valid_i),
        .ifu_rsp_inst_i  (ifu_rsp_inst_i),
        .inst_o          (inst),
        .pc_o            (pc),
        .jal_i           (jal_i),
        .jalr_i          (jalr_i),
        .br_taken_i      (br_taken_i),
        .imm_i           (imm_i),
        .rs1_i           (rs1_i),
        .mem_i           (mem_i),
        .ebreak_i        (ebreak_i),
        .lsu_req_valid_o (lsu_req_valid),
        .lsu_req_ready_i (lsu_req_ready_i),
        .lsu_rsp_valid_i (lsu_rsp_valid_i),
        .rd_wen_o        (rd_wen),
        .commit_o        (commit),
        .commit_pc_o     (commit_pc),
        .commit_inst_o   (commit_inst),
`ifdef MC_CTRL_PERF_EN
        .cycle_cnt_o     (cycle_cnt),
        .instret_cnt_o   (instret_cnt),
`endif
        .halt_o          (halt)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; cycles spent outside HALT are counted.
    task automatic step();
        @(posedge clk_i);
        if (!rst_i && !halted_m) cyc_m++;
        #1;
    endtask

    function automatic logic [31:0] ref_npc(input kind_e k, input logic [31:0] p,
                                            input logic [31:0] imm, input logic [31:0] rs1);
        logic [31:0] t;
        case (k)
            KJal, KBrT: t = p + imm;
            KJalr:      t = (rs1 + imm) & ~32'h1;
            default:    t = p + 32'd4;
        endcase
        return t;
    endfunction

    task automatic chk_idle(input string where);
        chk({where, "_commit"}, commit, 0);
        chk({where, "_rd_wen"}, rd_wen, 0);
        chk({where, "_commit_pc"}, commit_pc, 0);
    endtask

    task automatic reset_models();
        pc_m = RV;
        last_inst_m = '0;
        cyc_m = 0;
        ret_m = 0;
        halted_m = 0;
    endtask

    // Entered and left just after a rising edge, with the DUT at the start of a fetch.
    task automatic run_instr(input kind_e k, input logic [31:0] imm, input logic [31:0] rs1,
                             input int rqw, input int rsw, input int lqw, input int lsw,
                             input bit spur);
        logic [31:0] iw;
        int          lv;
        jal_i = (k == KJal);
        jalr_i = (k == KJalr);
        br_taken_i = (k == KBrT);
        mem_i = (k == KLoad) || (k == KEbreak);
        ebreak_i = (k == KEbreak);
        imm_i = imm;
        rs1_i = rs1;
`ifdef MC_CTRL_PERF_EN
        #1;
        chk("cycle_cnt", 64'(cycle_cnt), 64'(cyc_m % (1 << CW)));
        chk("instret_cnt", 64'(instret_cnt), 64'(ret_m % (1 << CW)));
`endif
        for (int i = 0; i < rqw; i++) begin
            ifu_req_ready_i = 1'b0;
            ifu_rsp_valid_i = spur && (i == rqw - 1);
            ifu_rsp_inst_i = spur ? 32'hDEAD_BEEF : 32'h0;
            #1;
            chk("fetch_valid_wait", ifu_req_valid, 1);
            chk("fetch_addr_wait", ifu_req_addr, pc_m);
            chk("inst_hold_wait", inst, last_inst_m);
            chk_idle("fetch_wait");
            step();
        end
        ifu_rsp_valid_i = 1'b0;
        ifu_rsp_inst_i = '0;
        ifu_req_ready_i = 1'b1;
        #1;
        chk("fetch_valid", ifu_req_valid, 1);
        chk("fetch_addr", ifu_req_addr, pc_m);
        chk("inst_hold", inst, last_inst_m);
        chk_idle("fetch_req");
        step();
        for (int i = 0; i < rsw; i++) begin
            ifu_req_ready_i = 1'($urandom_range(0, 1));
            #1;
            chk("fetch_valid_rsp_wait", ifu_req_valid, 0);
            chk_idle("rsp_wait");
            step();
        end
        ifu_req_ready_i = 1'b0;
        iw = $urandom;
        ifu_rsp_valid_i = 1'b1;
        ifu_rsp_inst_i = iw;
        #1;
        chk_idle("rsp");
        step();
        ifu_rsp_valid_i = 1'b0;
        ifu_rsp_inst_i = '0;
        #1;
        chk("exec_inst", inst, iw);
        chk("exec_commit", commit, k != KLoad);
        chk("exec_rd_wen", rd_wen, (k != KLoad) && (k != KEbreak));
        chk("exec_commit_pc", commit_pc, (k != KLoad) ? pc_m : 32'h0);
        chk("exec_commit_inst", commit_inst, (k != KLoad) ? iw : 32'h0);
        chk("exec_ifu_valid", ifu_req_valid, 0);
        step();
        last_inst_m = iw;
        if (k == KLoad) begin
            lv = 0;
            for (int i = 0; i <= lqw; i++) begin
                lsu_req_ready_i = (i == lqw);
                #1;
                if (lsu_req_valid) lv++;
                chk_idle("mem_req");
                step();
            end
            lsu_req_ready_i = 1'b0;
            chk("lsu_valid_cycles", lv, lqw + 1);
            for (int i = 0; i < lsw; i++) begin
                #1;
                chk("lsu_valid_rsp_wait", lsu_req_valid, 0);
                chk_idle("mem_wait");
                step();
            end
            lsu_rsp_valid_i = 1'b1;
            #1;
            chk("mem_commit", commit, 1);
            chk("mem_rd_wen", rd_wen, 1);
            chk("mem_commit_pc", commit_pc, pc_m);
            chk("mem_commit_inst", commit_inst, iw);
            step();
            lsu_rsp_valid_i = 1'b0;
        end
        ret_m++;
        if (k == KEbreak) halted_m = 1;
        else pc_m = ref_npc(k, pc_m, imm, rs1);
        {jal_i, jalr_i, br_taken_i, mem_i, ebreak_i} = '0;
    endtask

    initial begin
        tbl[0]  = '{32'h8000_0000, KAlu,  32'h0,         32'h0,         0, 0, 0, 0, 0};
        tbl[1]  = '{32'h8000_0004, KAlu,  32'h0,         32'h0,         0, 0, 0, 0, 0};
        tbl[2]  = '{32'h8000_0008, KAlu,  32'h0,         32'h0,         0, 0, 0, 0, 0};
        tbl[3]  = '{32'h8000_000C, KAlu,  32'h0,         32'h0,         1, 2, 0, 0, 0};
        tbl[4]  = '{32'h8000_0010, KJal,  32'h20,        32'h0,         0, 0, 0, 0, 0};
        tbl[5]  = '{32'h8000_0030, KJalr, 32'h4,         32'h8000_0101, 0, 0, 0, 0, 0};
        tbl[6]  = '{32'h8000_0104, KLoad, 32'h0,         32'h0,         0, 0, 3, 2, 0};
        tbl[7]  = '{32'h8000_0108, KBrT,  32'hFFFF_FFF8, 32'h0,         0, 0, 0, 0, 0};
        tbl[8]  = '{32'h8000_0100, KBrN,  32'h40,        32'h1234,      0, 0, 0, 0, 0};
        tbl[9]  = '{32'h8000_0104, KAlu,  32'h0,         32'h0,         5, 0, 0, 0, 1};
        tbl[10] = '{32'h8000_0108, KJal,  32'hFFFF_FF38, 32'h0,         0, 0, 0, 0, 0};

        reset_models();
        rst_i = 1'b1;
        step();
        step();
        chk("rst_ifu_valid", ifu_req_valid, 0);
        chk("rst_pc", pc, RV);
        chk("rst_inst", inst, 0);
        chk("rst_halt", halt, 0);
        chk("rst_lsu_valid", lsu_req_valid, 0);
        chk_idle("rst");
        rst_i = 1'b0;

        foreach (tbl[i]) begin
            #1;
            chk($sformatf("tbl%0d_fetch_addr", i), ifu_req_addr, tbl[i].pc);
            run_instr(tbl[i].k, tbl[i].imm, tbl[i].rs1, tbl[i].rqw, tbl[i].rsw, tbl[i].lqw,
                      tbl[i].lsw, tbl[i].spur);
        end

        // EBREAK with mem_i also high must still commit once and halt.
        #1;
        chk("ebreak_fetch_addr", ifu_req_addr, 32'h8000_0040);
        run_instr(KEbreak, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            ifu_req_ready_i = 1'b1;
            ifu_rsp_valid_i = 1'($urandom_range(0, 1));
            lsu_req_ready_i = 1'($urandom_range(0, 1));
            lsu_rsp_valid_i = 1'($urandom_range(0, 1));
            #1;
            chk("halt_sticky", halt, 1);
            chk("halt_ifu_valid", ifu_req_valid, 0);
            chk("halt_lsu_valid", lsu_req_valid, 0);
            chk("halt_pc", pc, 32'h8000_0040);
            chk_idle("halt");
            step();
        end
        {ifu_req_ready_i, ifu_rsp_valid_i, lsu_req_ready_i, lsu_rsp_valid_i} = '0;
`ifdef MC_CTRL_PERF_EN
        chk("halt_cycle_cnt", 64'(cycle_cnt), 64'(cyc_m % (1 << CW)));
`endif

        #3;
        rst_i = 1'b1;
        #1;
        chk("async_rst_pc", pc, RV);
        chk("async_rst_halt", halt, 0);
        chk("async_rst_ifu_valid", ifu_req_valid, 0);
        chk("async_rst_inst", inst, 0);
        reset_models();
        step();
        step();
        rst_i = 1'b0;

        for (int i = 0; i < 20; i++) run_instr(KAlu, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        #1;
        chk("alu20_fetch_addr", ifu_req_addr, 32'h8000_0050);
`ifdef MC_CTRL_PERF_EN
        chk("wrap_instret", 64'(instret_cnt), 64'd4);
        chk("wrap_cycle", 64'(cycle_cnt), 64'd12);
`endif

        for (int n = 0; n < 40; n++) begin
            kind_e k;
            int    rqw;
            k = kind_e'($urandom_range(0, 5));
            rqw = $urandom_range(0, 3);
            run_instr(k, $urandom, $urandom, rqw, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), (rqw > 0) && ($urandom_range(0, 3) == 0));
        end
        #1;
        chk("rand_final_fetch_addr", ifu_req_addr, pc_m);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control sequencer for the next-generation core, replacing the single-cycle PC/next-PC path.
- Owns the architectural PC and drives valid/ready handshakes to instruction memory and the LSU.
- Sequences each instruction through fetch, execute, optional memory access and commit.
- Decode, regfile and ALU stay combinational outside this block; it consumes their decoded flags and operands.
- Width, reset vector and counter width are parameters.

Parameters:
XLEN, 32, datapath and PC width
RESET_VECTOR, 32'h8000_0000, PC value after reset (XLEN bits)
CNT_W, 64, width of performance counters (used only with MC_CTRL_PERF_EN)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
ifu_req_valid_o  out  1  instruction fetch request valid
ifu_req_addr_o  out  XLEN  fetch address (= pc_o)
ifu_req_ready_i  in  1  IMEM accepts request
ifu_rsp_valid_i  in  1  fetch response valid
ifu_rsp_inst_i  in  32  fetched instruction
inst_o  out  32  latched instruction, held stable until next fetch completes
pc_o  out  XLEN  current PC
jal_i  in  1  decoded JAL
jalr_i  in  1  decoded JALR
br_taken_i  in  1  conditional branch resolved taken
imm_i  in  XLEN  decoded immediate
rs1_i  in  XLEN  rs1 read data
mem_i  in  1  instruction is load or store
ebreak_i  in  1  decoded EBREAK
lsu_req_valid_o  out  1  LSU request valid
lsu_req_ready_i  in  1  LSU accepts request
lsu_rsp_valid_i  in  1  LSU response (load data or store ack)
rd_wen_o  out  1  regfile write strobe, one-cycle pulse at commit
commit_o  out  1  instruction retired this cycle
commit_pc_o  out  XLEN  PC of retiring instruction
commit_inst_o  out  32  encoding of retiring instruction
halt_o  out  1  core halted after EBREAK (sticky)

Behaviour:
- States: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, HALT.
- Reset (async, rst_i=1):
  - state=FETCH_REQ, pc=RESET_VECTOR, inst_o=0, npc_r=0.
  - ifu_req_valid_o=0 while rst_i is high.
  - All other valid/strobe outputs = 0; halt_o=0.
  - Reset mid-operation aborts any outstanding transaction; responses arriving after reset are ignored until the next request is issued.
- FETCH_REQ: ifu_req_valid_o=1, addr=pc. On ifu_req_ready_i, go to FETCH_WAIT. ifu_rsp_valid_i is ignored in this state.
- FETCH_WAIT: on ifu_rsp_valid_i, latch inst_o and go to EXEC. Waits indefinitely.
- EXEC (exactly one cycle), next-PC calculation:
  - base = jalr_i ? rs1_i : pc.
  - off = (jal_i|jalr_i|br_taken_i) ? imm_i : 4.
  - npc = base + off, modulo 2^XLEN; bit0 forced to 0 when jalr_i.
  - npc is captured into npc_r.
- EXEC, ebreak_i=1 (priority over mem_i): commit_o=1, rd_wen_o=0, go to HALT; pc not updated.
- EXEC, mem_i=1: go to MEM_REQ; no commit.
- EXEC, otherwise: commit_o=1, rd_wen_o=1 (regfile gates x0 / no-rd), pc<=npc, go to FETCH_REQ.
- MEM_REQ: lsu_req_valid_o=1; on lsu_req_ready_i go to MEM_WAIT.
- MEM_WAIT: on lsu_rsp_valid_i:
  - commit_o=1 and rd_wen_o=1 (write-back for loads; stores rely on the regfile's own gating).
  - pc<=npc_r, go to FETCH_REQ.
- Commit fields: commit_pc_o and commit_inst_o = pc and inst_o during the commit cycle; 0 otherwise.
- HALT: absorbing; no requests issued; halt_o=1; only reset exits.
- Valid outputs are asserted from state decode only; they never depend combinationally on ready inputs.
- Minimum latency: ALU/branch instruction 3 cycles (zero-wait memory); load/store 5 cycles.

Optional Feature:
MC_CTRL_PERF_EN
- Defined: adds outputs cycle_cnt_o [CNT_W] and instret_cnt_o [CNT_W].
  - Both reset to 0.
  - cycle_cnt_o increments every cycle except in HALT.
  - instret_cnt_o increments on each commit_o.
  - Both wrap modulo 2^CNT_W.
- Undefined: neither port nor any counter logic exists.

Test Plan:
- Reset release, ready=1, rsp one cycle later, addi stream → fetch addrs 0x80000000, 0x80000004, 0x80000008; commit_o every 3rd cycle; rd_wen_o pulses one cycle each.
- JAL at 0x80000010 with imm=0x20 → next fetch 0x80000030. JALR with rs1=0x80000101, imm=4 → next fetch 0x80000104 (bit0 cleared).
- Load with lsu_req_ready_i delayed 3 cycles and rsp delayed 2 → lsu_req_valid_o held 4 cycles; commit and rd_wen_o exactly on the rsp cycle; next fetch pc+4.
- ifu_req_ready_i low 5 cycles, then spurious ifu_rsp_valid_i pulsed in FETCH_REQ → request held stable; spurious pulse ignored; inst_o unchanged.
- EBREAK at 0x80000040 → commit_o=1 once; halt_o=1 sticky; no further ifu_req_valid_o for 20 cycles. Then assert rst_i asynchronously mid-cycle → pc_o=0x80000000 immediately.
- MC_CTRL_PERF_EN with CNT_W=4, 20 ALU instrs → instret_cnt_o wraps to 4; cycle_cnt_o = 60 mod 16 = 12.
